// File: rtl/reg_bus_pkg.sv
// Shared types and helpers for the MAC CPU register-bus master.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_RMW   = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_CAP  = 3'd2,
    WR      = 3'd3,
    GAP     = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam int GAP_CNT_W = 4;

  // Read-modify-write merge: mask bits set take the new data bit.
  function automatic logic [15:0] rmw_merge(input logic [15:0] cur,
                                            input logic [15:0] wdata,
                                            input logic [15:0] mask);
    return (cur & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/reg_bus_master.sv
// Register-bus initiator: turns host READ / WRITE / RMW commands into
// CSB/WRB/CA/CD_in cycles on the MAC register port, one response per command.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// RD_ADDR | CSB low, WRB high, read address on CA
// RD_CAP  | CSB high, bank's registered CD_out captured
// WR      | CSB low, WRB low, write data on CD_in
// GAP     | bus idle for GAP_CYC cycles, then gap_ret
// RSP     | response held until rsp_ready
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int GAP_CYC = 1,
  parameter int ADDR_W  = 7
) (
  input  logic              Clk_reg,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [15:0]       cmd_wdata,
  input  logic [15:0]       cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic              rsp_err,
  output logic              CSB,
  output logic              WRB,
  output logic [7:0]        CA,
  output logic [15:0]       CD_in,
  input  logic [15:0]       CD_out,
  output logic              busy
);

  localparam logic                 GAP_EN   = (GAP_CYC > 0);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_CNT_W'(GAP_CYC - 1)
                                                            : '0;

  state_t              state;
  state_t              state_nxt;
  state_t              gap_ret;
  op_t                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic [15:0]         mask_q;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                accept;
  op_t                 cmd_op_t;

  assign cmd_op_t = op_t'(cmd_op);
  assign accept   = cmd_valid && cmd_ready;

  // State register.
  always_ff @(posedge Clk_reg) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op_t)
            OP_READ, OP_RMW: state_nxt = RD_ADDR;
            OP_WRITE:        state_nxt = WR;
            default:         state_nxt = RSP;
          endcase
        end
      end
      RD_ADDR: state_nxt = RD_CAP;
      RD_CAP: begin
        if (GAP_EN)               state_nxt = GAP;
        else if (op_q == OP_RMW)  state_nxt = WR;
        else                      state_nxt = RSP;
      end
      WR:      state_nxt = GAP_EN ? GAP : RSP;
      GAP:     if (gap_cnt == '0) state_nxt = gap_ret;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus strobes and handshake outputs decoded from state.
  always_comb begin
    CSB       = 1'b1;
    WRB       = 1'b1;
    cmd_ready = (state == IDLE) && Reset;
    rsp_valid = (state == RSP);
    busy      = (state != IDLE);
    case (state)
      RD_ADDR: CSB = 1'b0;
      WR: begin
        CSB = 1'b0;
        WRB = 1'b0;
      end
      default: ;
    endcase
  end

  // Command latch, taken once per accepted command.
  always_ff @(posedge Clk_reg) begin
    if (!Reset) begin
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else if (accept) begin
      op_q    <= cmd_op_t;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      mask_q  <= cmd_mask;
    end
  end

  // Response registers; rsp_data doubles as the read-capture register.
  always_ff @(posedge Clk_reg) begin
    if (!Reset) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rsp_data <= '0;
      rsp_err  <= (cmd_op_t == OP_RSVD);
    end else if (state == RD_CAP) begin
      rsp_data <= CD_out;
    end
  end

  // CA / CD_in are loaded only when entering a bus state so they hold between accesses.
  // With no gap an RMW goes RD_CAP -> WR directly, so the merge must use CD_out itself.
  always_ff @(posedge Clk_reg) begin
    if (!Reset) begin
      CA    <= '0;
      CD_in <= '0;
    end else if (state_nxt == RD_ADDR) begin
      CA <= 8'({cmd_addr, 1'b0});
    end else if (state_nxt == WR) begin
      if (state == IDLE) begin
        CA    <= 8'({cmd_addr, 1'b0});
        CD_in <= cmd_wdata;
      end else begin
        CA    <= 8'({addr_q, 1'b0});
        CD_in <= rmw_merge((state == RD_CAP) ? CD_out : rsp_data, wdata_q, mask_q);
      end
    end
  end

  // Gap down-counter and the state to resume once it reaches terminal count.
  always_ff @(posedge Clk_reg) begin
    if (!Reset) begin
      gap_cnt <= '0;
      gap_ret <= RSP;
    end else if (state == RD_CAP) begin
      gap_cnt <= GAP_LOAD;
      gap_ret <= (op_q == OP_RMW) ? WR : RSP;
    end else if (state == WR) begin
      gap_cnt <= GAP_LOAD;
      gap_ret <= RSP;
    end else if (state == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: directed table, hand-written corner
// sequences, and randomized commands against a command-level reference model.
module tb_reg_bus_master;

  localparam int GAP = 1;

  logic        Clk_reg = 1'b0;
  logic        Reset   = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op    = 2'd0;
  logic [6:0]  cmd_addr  = 7'd0;
  logic [15:0] cmd_wdata = 16'd0;
  logic [15:0] cmd_mask  = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        CSB;
  logic        WRB;
  logic [7:0]  CA;
  logic [15:0] CD_in;
  logic [15:0] CD_out = 16'd0;
  logic        busy;

  reg_bus_master #(.GAP_CYC(GAP), .ADDR_W(7)) dut (
    .Clk_reg(Clk_reg), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .CSB(CSB), .WRB(WRB), .CA(CA), .CD_in(CD_in),
    .CD_out(CD_out), .busy(busy)
  );

  always #5 Clk_reg = ~Clk_reg;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Register bank: registered read data valid only in the cycle after CSB low.
  logic [15:0] mem [128];
  logic [15:0] ref_mem [128];
  logic [15:0] rd_cd = 16'd0;

  function automatic logic [15:0] init_val(input int i);
    if (i == 0)  return 16'h003C;
    if (i == 34) return 16'h0002;
    return 16'(i * 16'h0111 + 16'h0007);
  endfunction

  always @(negedge Clk_reg) begin
    rd_cd = 16'($urandom);
    if (CSB === 1'b0) begin
      if (WRB) rd_cd = mem[CA[7:1]];
      else     mem[CA[7:1]] = CD_in;
    end
  end

  always @(posedge Clk_reg) CD_out <= rd_cd;

  // Bus monitor: logs accesses and counts protocol violations.
  typedef struct {
    int          cyc;
    logic        wr;
    logic [7:0]  ca;
    logic [15:0] cd;
  } bus_ev_t;

  bus_ev_t evq[$];
  int cyc = 0;
  int last_bus = -1;
  int proto_err = 0;

  always @(negedge Clk_reg) begin
    bus_ev_t ev;
    cyc++;
    if (Reset === 1'b1) begin
      if (CSB === 1'b1 && WRB === 1'b0) proto_err++;
      if (CSB === 1'b0) begin
        if (last_bus >= 0 && (cyc - last_bus - 1) < GAP) proto_err++;
        last_bus = cyc;
        ev.cyc = cyc;
        ev.wr  = ~WRB;
        ev.ca  = CA;
        ev.cd  = CD_in;
        evq.push_back(ev);
      end
    end
  end

  // Command-level reference: response, written value, latency, bus access count.
  task automatic model(input logic [1:0] op, input logic [6:0] a,
                       input logic [15:0] wd, input logic [15:0] mk,
                       output logic [15:0] d, output logic e,
                       output logic [15:0] wcd, output int lat, output int nbus);
    d = 16'd0; e = 1'b0; wcd = 16'd0;
    case (op)
      2'd0: begin d = ref_mem[a]; lat = 3 + GAP; nbus = 1; end
      2'd1: begin ref_mem[a] = wd; wcd = wd; lat = 2 + GAP; nbus = 1; end
      2'd2: begin
        d = ref_mem[a];
        wcd = (d & ~mk) | (wd & mk);
        ref_mem[a] = wcd;
        lat = 4 + 2 * GAP;
        nbus = 2;
      end
      default: begin e = 1'b1; lat = 1; nbus = 0; end
    endcase
  endtask

  // Issue one command, hold rsp_ready low for 'hold' cycles, and check everything.
  task automatic exec(input string nm, input logic [1:0] op, input logic [6:0] a,
                      input logic [15:0] wd, input logic [15:0] mk, input int hold,
                      input logic [15:0] exp_d, input logic exp_e, input int exp_lat,
                      input int nbus, input logic [15:0] wcd);
    int b;
    int lat;
    evq.delete();
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = mk;
    rsp_ready = (hold == 0);
    b = 0;
    while (cmd_ready !== 1'b1 && b < 20) begin @(posedge Clk_reg); #1; b++; end
    chk({nm, " cmd_ready"}, cmd_ready, 1);
    @(posedge Clk_reg); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = 7'($urandom);
    cmd_wdata = 16'($urandom); cmd_mask = 16'($urandom);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin @(posedge Clk_reg); #1; lat++; end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " rsp_data"}, rsp_data, exp_d);
    chk({nm, " rsp_err"}, rsp_err, exp_e);
    for (int h = 0; h < hold; h++) begin
      @(posedge Clk_reg); #1;
      chk({nm, " hold rsp_valid"}, rsp_valid, 1);
      chk({nm, " hold rsp_data"}, rsp_data, exp_d);
      chk({nm, " hold CSB"}, CSB, 1);
    end
    rsp_ready = 1'b1;
    @(posedge Clk_reg); #1;
    chk({nm, " idle after rsp"}, busy, 0);
    chk({nm, " bus count"}, evq.size(), nbus);
    if (evq.size() == nbus) begin
      for (int i = 0; i < nbus; i++) begin
        chk({nm, " CA"}, evq[i].ca, {a, 1'b0});
        chk({nm, " WRB"}, evq[i].wr, (op == 2'd1) || (op == 2'd2 && i == 1));
        if (evq[i].wr) chk({nm, " CD_in"}, evq[i].cd, wcd);
      end
      // Read address cycle, capture cycle, then GAP idle cycles before the write.
      if (nbus == 2) chk({nm, " rmw spacing"}, evq[1].cyc - evq[0].cyc, 2 + GAP);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [15:0] wd;
    logic [15:0] mk;
    logic [15:0] exp_d;
    logic        exp_e;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] md, wcd;
    logic        me;
    int          mlat, nbus, b;

    for (int i = 0; i < 128; i++) begin
      mem[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end

    vecs[0]  = '{2'd0, 7'd0,   16'h0000, 16'h0000, 16'h003C, 1'b0, 4};
    vecs[1]  = '{2'd1, 7'd26,  16'd1518, 16'h0000, 16'h0000, 1'b0, 3};
    vecs[2]  = '{2'd0, 7'd26,  16'h0000, 16'h0000, 16'h05EE, 1'b0, 4};
    vecs[3]  = '{2'd2, 7'd34,  16'h0004, 16'h0007, 16'h0002, 1'b0, 6};
    vecs[4]  = '{2'd0, 7'd34,  16'h0000, 16'h0000, 16'h0004, 1'b0, 4};
    vecs[5]  = '{2'd3, 7'd5,   16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1};
    vecs[6]  = '{2'd2, 7'd34,  16'hABCD, 16'hFFF0, 16'h0004, 1'b0, 6};
    vecs[7]  = '{2'd0, 7'd34,  16'h0000, 16'h0000, 16'hABC4, 1'b0, 4};
    vecs[8]  = '{2'd1, 7'd127, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 3};
    vecs[9]  = '{2'd0, 7'd127, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 4};
    vecs[10] = '{2'd2, 7'd127, 16'h0000, 16'h00FF, 16'hFFFF, 1'b0, 6};
    vecs[11] = '{2'd0, 7'd127, 16'h0000, 16'h0000, 16'hFF00, 1'b0, 4};

    // Reset values.
    Reset = 1'b0;
    repeat (3) @(posedge Clk_reg);
    #1;
    chk("rst CSB", CSB, 1);
    chk("rst WRB", WRB, 1);
    chk("rst CA", CA, 0);
    chk("rst CD_in", CD_in, 0);
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst busy", busy, 0);
    Reset = 1'b1;
    #1;
    chk("release cmd_ready", cmd_ready, 1);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      model(vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].mk, md, me, wcd, mlat, nbus);
      exec($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].mk, 0,
           vecs[i].exp_d, vecs[i].exp_e, vecs[i].exp_lat, nbus, wcd);
    end

    // Response back-pressure with a competing command offered.
    model(2'd0, 7'd0, 16'h0, 16'h0, md, me, wcd, mlat, nbus);
    evq.delete();
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 7'd0; rsp_ready = 1'b0;
    @(posedge Clk_reg); #1;
    cmd_valid = 1'b0;
    b = 0;
    while (rsp_valid !== 1'b1 && b < 20) begin @(posedge Clk_reg); #1; b++; end
    chk("bp rsp_valid", rsp_valid, 1);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 7'd9; cmd_wdata = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk_reg); #1;
      chk("bp rsp_valid held", rsp_valid, 1);
      chk("bp rsp_data held", rsp_data, md);
      chk("bp cmd_ready", cmd_ready, 0);
      chk("bp bus quiet", evq.size(), 1);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge Clk_reg); #1;
    chk("bp idle", busy, 0);
    chk("bp rsp_valid drop", rsp_valid, 0);
    repeat (3) @(posedge Clk_reg);
    #1;
    chk("bp no extra cmd", evq.size(), 1);
    chk("bp still idle", busy, 0);
    model(2'd0, 7'd9, 16'h0, 16'h0, md, me, wcd, mlat, nbus);
    exec("bp addr9 untouched", 2'd0, 7'd9, 16'h0, 16'h0, 0, md, me, mlat, nbus, wcd);

    // Reserved op with back-pressure: no bus cycle at all.
    model(2'd3, 7'd77, 16'hBEEF, 16'hFFFF, md, me, wcd, mlat, nbus);
    exec("rsvd", 2'd3, 7'd77, 16'hBEEF, 16'hFFFF, 3, md, me, mlat, nbus, wcd);

    // Reset during the write strobe: no response, strobe already landed.
    evq.delete();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 7'd50; cmd_wdata = 16'hC0DE;
    rsp_ready = 1'b1;
    @(posedge Clk_reg); #1;
    cmd_valid = 1'b0;
    chk("mid-wr CSB", CSB, 0);
    chk("mid-wr WRB", WRB, 0);
    Reset = 1'b0;
    @(posedge Clk_reg); #1;
    chk("wr-rst CSB", CSB, 1);
    chk("wr-rst WRB", WRB, 1);
    chk("wr-rst CA", CA, 0);
    chk("wr-rst CD_in", CD_in, 0);
    chk("wr-rst cmd_ready", cmd_ready, 0);
    chk("wr-rst rsp_valid", rsp_valid, 0);
    chk("wr-rst rsp_data", rsp_data, 0);
    chk("wr-rst busy", busy, 0);
    Reset = 1'b1;
    #1;
    chk("wr-rst release cmd_ready", cmd_ready, 1);
    repeat (4) @(posedge Clk_reg);
    #1;
    chk("wr-rst no response", rsp_valid, 0);
    chk("wr-rst idle", busy, 0);
    ref_mem[50] = 16'hC0DE;
    model(2'd0, 7'd50, 16'h0, 16'h0, md, me, wcd, mlat, nbus);
    exec("read after wr-rst", 2'd0, 7'd50, 16'h0, 16'h0, 0, md, me, mlat, nbus, wcd);

    // Randomized commands against the reference model.
    for (int n = 0; n < 150; n++) begin
      int          r, hold;
      logic [1:0]  op;
      logic [6:0]  a;
      logic [15:0] wd, mk;
      r  = $urandom_range(0, 9);
      op = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = 7'($urandom_range(0, 15));
      wd = 16'($urandom);
      mk = 16'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      model(op, a, wd, mk, md, me, wcd, mlat, nbus);
      exec($sformatf("rnd%0d op%0d a%0d", n, op, a), op, a, wd, mk, hold,
           md, me, mlat, nbus, wcd);
    end

    chk("protocol violations", proto_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
